// File: rtl/vic_pkg.sv
// Shared definitions for the vectored interrupt controller priority scheduler:
// default sizes, scheduler state encoding and the nesting-depth width helper.
package vic_pkg;

  localparam int N_IRQ_DEF  = 31;
  localparam int PRIO_W_DEF = 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  // Counter width able to hold every value 0..depth inclusive.
  function automatic int depth_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/vic_prio_enc.sv
// Combinational priority encoder: picks the highest-priority line in the
// eligible mask; on equal priority the lowest index wins.
module vic_prio_enc
  import vic_pkg::*;
#(
  parameter int N_IRQ  = N_IRQ_DEF,
  parameter int PRIO_W = PRIO_W_DEF
) (
  input  logic [N_IRQ-1:0]        elig,
  input  logic [N_IRQ*PRIO_W-1:0] prio,
  output logic                    valid,
  output logic [4:0]              idx,
  output logic [PRIO_W-1:0]       win_prio
);

  logic cand_s;

  // Ascending scan; only a strictly greater priority displaces the current best.
  always_comb begin
    valid    = 1'b0;
    idx      = 5'd0;
    win_prio = '0;
    cand_s   = 1'b0;
    for (int k = 0; k < N_IRQ; k++) begin
      cand_s   = elig[k] & (~valid | (prio[k*PRIO_W +: PRIO_W] > win_prio));
      idx      = cand_s ? 5'(k) : idx;
      win_prio = cand_s ? prio[k*PRIO_W +: PRIO_W] : win_prio;
      valid    = valid | cand_s;
    end
  end

endmodule

// File: rtl/vic_prio_sched.sv
// Nested-priority interrupt scheduler: arbitrates eligible pending lines,
// presents one vector request and tracks active priorities on a nesting stack.
module vic_prio_sched
  import vic_pkg::*;
#(
  parameter int N_IRQ  = N_IRQ_DEF,
  parameter int PRIO_W = PRIO_W_DEF,
  parameter int DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_IRQ-1:0]              i_pending,
  input  logic [N_IRQ-1:0]              i_irq_en,
  input  logic [N_IRQ*PRIO_W-1:0]       i_prio,
  input  logic                          i_gen,
  input  logic                          i_ack,
  input  logic                          i_reti,
  output logic                          o_IRQ,
  output logic [4:0]                    o_irq_addr,
  output logic [N_IRQ-1:0]              o_clr,
  output logic [PRIO_W-1:0]             o_active_prio,
  output logic [depth_w(DEPTH)-1:0]     o_depth,
  output logic                          o_full,
  output logic                          o_underflow
);

  localparam int DW = depth_w(DEPTH);

  state_t              state_r;
  logic [PRIO_W-1:0]   win_prio_r;
  logic [PRIO_W-1:0]   stack_r [DEPTH];
  logic [N_IRQ-1:0]    elig_s;
  logic                win_valid_s;
  logic [4:0]          win_idx_s;
  logic [PRIO_W-1:0]   win_prio_s;
  logic                push_s;
  logic                pop_s;
  logic                hold_s;
  logic [DW-1:0]       depth_nxt_s;

  // Per-line eligibility against global enable, saturation and the running ISR priority.
  always_comb begin
    elig_s = '0;
    for (int k = 0; k < N_IRQ; k++) begin
      elig_s[k] = i_pending[k] & i_irq_en[k] & i_gen & ~o_full &
                  ((o_depth == DW'(0)) | (i_prio[k*PRIO_W +: PRIO_W] > o_active_prio));
    end
  end

  vic_prio_enc #(
    .N_IRQ  (N_IRQ),
    .PRIO_W (PRIO_W)
  ) u_enc (
    .elig     (elig_s),
    .prio     (i_prio),
    .valid    (win_valid_s),
    .idx      (win_idx_s),
    .win_prio (win_prio_s)
  );

  // Stack control: a same-cycle reti and ack pop first and then push.
  always_comb begin
    push_s      = (state_r == S_REQ) & i_ack;
    pop_s       = i_reti & (o_depth != DW'(0));
    hold_s      = i_pending[o_irq_addr] & i_irq_en[o_irq_addr] & i_gen;
    depth_nxt_s = o_depth - DW'(pop_s) + DW'(push_s);
  end

  // Scheduler FSM with registered request, address and pending-clear outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= S_IDLE;
      win_prio_r <= '0;
      o_IRQ      <= 1'b0;
      o_irq_addr <= 5'd0;
      o_clr      <= '0;
    end else begin
      case (state_r)
        S_IDLE: begin
          o_clr <= '0;
          if (win_valid_s) begin
            state_r    <= S_REQ;
            o_irq_addr <= win_idx_s;
            win_prio_r <= win_prio_s;
            o_IRQ      <= 1'b1;
          end else begin
            o_IRQ <= 1'b0;
          end
        end
        S_REQ: begin
          if (i_ack) begin
            state_r <= S_GAP;
            o_IRQ   <= 1'b0;
            o_clr   <= {{(N_IRQ-1){1'b0}}, 1'b1} << o_irq_addr;
          end else if (!hold_s) begin
            state_r <= S_IDLE;
            o_IRQ   <= 1'b0;
          end else begin
            o_IRQ <= 1'b1;
          end
        end
        S_GAP: begin
          state_r <= S_IDLE;
          o_clr   <= '0;
          o_IRQ   <= 1'b0;
        end
        default: begin
          state_r <= S_IDLE;
          o_clr   <= '0;
          o_IRQ   <= 1'b0;
        end
      endcase
    end
  end

  // Shift-register stack: entry 0 is always the top, vacated slots refill with zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) stack_r[i] <= '0;
      o_depth     <= '0;
      o_full      <= 1'b0;
      o_underflow <= 1'b0;
    end else begin
      if (push_s && pop_s) begin
        stack_r[0] <= win_prio_r;
      end else if (pop_s) begin
        for (int i = 0; i < DEPTH - 1; i++) stack_r[i] <= stack_r[i+1];
        stack_r[DEPTH-1] <= '0;
      end else if (push_s) begin
        for (int i = 1; i < DEPTH; i++) stack_r[i] <= stack_r[i-1];
        stack_r[0] <= win_prio_r;
      end else begin
        stack_r[0] <= stack_r[0];
      end
      o_depth     <= depth_nxt_s;
      o_full      <= (depth_nxt_s == DW'(DEPTH));
      o_underflow <= o_underflow | (i_reti & (o_depth == DW'(0)));
    end
  end

  assign o_active_prio = stack_r[0];

endmodule

// File: doc/vic_prio_sched.md
Name: vic_prio_sched

Overview:
- Nested-priority scheduler for the vectored interrupt controller.
- Sits between the interrupt-line capture stage and the VIC control unit.
- Each cycle it picks the highest-priority enabled pending line allowed to preempt the running ISR, and presents it as a vector request.
- Keeps a nesting stack of active priorities: push on acknowledge, pop on return-from-interrupt.

Parameters:
- N_IRQ, 31, number of external interrupt lines.
- PRIO_W, 2, width of the per-line priority field (larger value = more urgent).
- DEPTH, 4, maximum nesting depth of the active-priority stack.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous reset, active-high
- i_pending  in  N_IRQ  latched pending flags from the capture stage
- i_irq_en  in  N_IRQ  per-line enable
- i_prio  in  N_IRQ*PRIO_W  per-line priority; line k uses bits [k*PRIO_W +: PRIO_W]
- i_gen  in  1  global interrupt enable
- i_ack  in  1  control unit has taken the presented vector
- i_reti  in  1  one-cycle pulse, ISR return
- o_IRQ  out  1  vector request to the control unit
- o_irq_addr  out  5  index of the requested line
- o_clr  out  N_IRQ  one-hot, one-cycle pending-clear pulse to the capture stage
- o_active_prio  out  PRIO_W  priority at top of stack (0 when empty)
- o_depth  out  clog2(DEPTH+1)  current nesting depth
- o_full  out  1  depth == DEPTH
- o_underflow  out  1  sticky error flag: reti received with empty stack

Behaviour:
- Reset: every output is 0, state S_IDLE, stack cleared, depth 0.
  - Reset overrides any in-progress request or pending ack.
- Eligibility: line k is eligible when all of the following hold:
  - i_pending[k] & i_irq_en[k] & i_gen & !o_full;
  - depth == 0, or prio[k] > o_active_prio (strictly greater; equal priority never preempts).
- Winner: highest prio among eligible lines; ties go to the lowest index.
- FSM:
  - S_IDLE:
    - Any eligible line: register winner index and prio, go to S_REQ.
    - Latency: o_IRQ rises the cycle after the line becomes eligible.
  - S_REQ:
    - o_IRQ = 1; o_irq_addr is held stable, with no re-arbitration.
    - On i_ack: push winner prio, depth+1, o_clr[winner] = 1 for the next cycle, go to S_GAP.
    - Withdraw: if the winner loses eligibility and i_ack is low, go to S_IDLE and o_IRQ drops next cycle. Loss of eligibility means its i_pending, i_irq_en, or i_gen is cleared.
    - i_ack in the same cycle as withdrawal: ack wins.
  - S_GAP:
    - One blanking cycle in which o_clr is asserted and no arbitration occurs.
    - Prevents re-selecting the line whose pending flag has not yet cleared.
    - Go to S_IDLE.
- o_IRQ is high only in S_REQ. o_irq_addr holds its last value in the other states.
- i_reti with depth > 0: pop, depth-1, effective on the next edge, in any state.
- i_reti with depth == 0: ignored, and o_underflow is set. The flag clears only on rst.
- Same-cycle i_reti and i_ack: pop is applied, then push, so depth is unchanged and top = new winner prio.
- i_reti during S_REQ: the request stays up. Eligibility is re-evaluated against the new top.
- i_ack outside S_REQ: ignored.
- Saturation: with o_full = 1 no line is eligible and the stack never overflows.

Decomposition:
- Shared package vic_pkg holds:
  - N_IRQ and PRIO_W defaults;
  - state encoding localparams S_IDLE, S_REQ, S_GAP;
  - a function for the stack-depth width.
- One natural combinational sub-module, vic_prio_enc. It takes the eligible mask and the priority vector and returns a valid flag, winner index and winner prio. It is instantiated once.

Test Plan:
1. depth 0; i_pending[5] = 1, prio 1, enabled, i_gen = 1 -> o_IRQ = 1, o_irq_addr = 5 next cycle. Ack -> o_clr = 1<<5 for one cycle, o_depth = 1, o_active_prio = 1.
2. Nesting, with line 5 (prio 1) active:
   - raise line 2 (prio 1) and line 9 (prio 3) -> request addr 9 only;
   - ack -> depth 2;
   - reti -> depth 1, line 2 still not requested;
   - second reti -> depth 0, line 2 requested.
3. Tie: lines 7 and 3 both prio 2, raised in the same cycle -> o_irq_addr = 3.
4. DEPTH = 2 instance: ack prio 0 then prio 2; raise prio-3 line -> o_full = 1, o_IRQ stays 0 until reti.
5. In S_REQ for line 4, clear i_irq_en[4] -> o_IRQ falls next cycle, no o_clr. Repeat with i_ack in the same cycle -> ack taken, o_clr[4] pulses.
6. Edge cases:
   - reti at depth 0 -> o_underflow = 1 and stays 1;
   - rst asserted mid-S_REQ -> all outputs 0 on the next cycle, depth 0, o_underflow cleared.
